param_updown_counter: RTL

//   Parametrised, fully synchronous up/down counter; successor to the fixed 3-bit up counter.

---
 rtl/param_updown_counter.sv | 111 +++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//   Parametrised synchronous up/down event/timebase counter. Counts over
//   0..MODULO-1 (any MODULO, not only powers of two), either wrapping or
//   saturating at the range ends. Supports synchronous clear, parallel load
//   with clamping, count enable and per-edge direction control. Reports
//   wrap/saturation events as a one-cycle pulse and as a sticky flag.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   MODULO     count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   SATURATE   0: wrap at range ends, 1: hold at range ends
//   RESET_VAL  count_out value after reset (< MODULO)
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   clr        in   1      synchronous clear of count and sticky flag
//   load       in   1      synchronous parallel load of load_val (clamped)
//   load_val   in   WIDTH  value to load
//   en         in   1      count enable
//   up_dn      in   1      1: count up, 0: count down
//   count_out  out  WIDTH  registered count
//   tc         out  1      combinational: next edge produces a wrap/sat event
//   wrap_pulse out  1      registered one-cycle event pulse
//   sticky_evt out  1      registered sticky event flag
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MODULO    = 2**WIDTH,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             sticky_evt
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sticky_q, sticky_d;

  logic at_max;
  logic at_zero;
  logic event_hit;

  always_comb begin
    at_max    = (count_q == MAX_VAL);
    at_zero   = (count_q == '0);
    // A step at a range end is the only source of wrap/saturation events.
    event_hit = en & ((up_dn & at_max) | (~up_dn & at_zero));
    tc        = event_hit & ~clr & ~load;

    count_d  = count_q;
    wrap_d   = 1'b0;
    sticky_d = sticky_q;

    if (clr) begin
      count_d  = '0;
      sticky_d = 1'b0;
    end else if (load) begin
      // Widen before comparing so MODULO == 2**WIDTH does not overflow.
      if ({1'b0, load_val} >= MOD_EXT) begin
        count_d = MAX_VAL;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      if (event_hit) begin
        wrap_d   = 1'b1;
        sticky_d = 1'b1;
        if (!SATURATE) begin
          count_d = up_dn ? '0 : MAX_VAL;
        end
      end else if (up_dn) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= RST_VAL;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  assign count_out  = count_q;
  assign wrap_pulse = wrap_q;
  assign sticky_evt = sticky_q;

endmodule
